uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one UART byte transmitter among NUM_REQ requesters. Each requester streams bytes with a valid/ready/last handshake. A grant is held for a whole message, ending on last, MAX_BURST bytes, or an idle timeout, so messages never interleave on the serial line. Sits between software/bus-side byte sources and the UART TX (data_tx/valid_tx/ready_tx interface).

---
 rtl/uart_tx_arbiter.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART byte transmitter among NUM_REQ sources
//
// Ports:
//   clk        clock
//   rst        synchronous reset, active-high
//   req_data   requester i byte at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_valid  per-requester byte valid
//   req_last   per-requester last byte of message (sampled with valid)
//   req_ready  per-requester accept, only the granted bit can be set
//   tx_data    byte to UART TX
//   tx_valid   byte valid to UART TX
//   tx_ready   UART TX ready
//   grant_id   current / most recent granted requester
//   busy       high whenever a grant is active

module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int MAX_BURST    = 16,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int IW = $clog2(IDLE_TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_DRAIN} state_t;

  state_t                  state;
  logic [GW-1:0]           rr_ptr;
  logic [GW-1:0]           rr_pick;
  logic [GW-1:0]           next_ptr;
  logic                    rr_found;
  logic [2*NUM_REQ-1:0]    rot_valid;
  logic [BW-1:0]           burst_cnt;
  logic [IW-1:0]           idle_cnt;
  logic                    last_r;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    sel_valid;
  logic                    sel_last;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [GW-1:0] id);
    logic [NUM_REQ-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  // Rotate the request vector so bit 0 is the requester at rr_ptr; the
  // first set bit k then maps back to (rr_ptr + k) mod NUM_REQ.
  always_comb begin
    rot_valid = {req_valid, req_valid} >> rr_ptr;
    rr_found  = 1'b0;
    rr_pick   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!rr_found && rot_valid[k]) begin
        rr_found = 1'b1;
        rr_pick  = GW'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  // Lanes of the granted requester.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == GW'(i)) begin
        sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
      end
    end
  end

  assign next_ptr = (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + GW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      req_ready <= '0;
      grant_id  <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      idle_cnt  <= '0;
      last_r    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rr_found) begin
            grant_id  <= rr_pick;
            req_ready <= onehot(rr_pick);
            burst_cnt <= '0;
            idle_cnt  <= '0;
            busy      <= 1'b1;
            state     <= S_GRANT;
          end
        end

        S_GRANT: begin
          if (sel_valid) begin
            tx_data   <= sel_data;
            tx_valid  <= 1'b1;
            last_r    <= sel_last;
            burst_cnt <= burst_cnt + BW'(1);
            idle_cnt  <= '0;
            req_ready <= '0;
            state     <= S_DRAIN;
          end else begin
            idle_cnt <= idle_cnt + IW'(1);
            // Release on the cycle the count reaches IDLE_TIMEOUT-1.
            if (idle_cnt == IW'(IDLE_TIMEOUT - 2)) begin
              rr_ptr    <= next_ptr;
              req_ready <= '0;
              busy      <= 1'b0;
              state     <= S_IDLE;
            end
          end
        end

        S_DRAIN: begin
          // tx_valid is always high here, so tx_ready alone is the handshake.
          if (tx_ready) begin
            tx_valid <= 1'b0;
            if (last_r || (burst_cnt == BW'(MAX_BURST))) begin
              rr_ptr <= next_ptr;
              busy   <= 1'b0;
              state  <= S_IDLE;
            end else begin
              req_ready <= onehot(grant_id);
              state     <= S_GRANT;
            end
          end
        end

        default: begin
          req_ready <= '0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter

module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int IT = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_last;
  logic [NR-1:0]    req_ready;
  logic [DW-1:0]    tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [1:0]       grant_id;
  logic             busy;

  uart_tx_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB), .IDLE_TIMEOUT(IT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_data(req_data), .req_valid(req_valid), .req_last(req_last),
    .req_ready(req_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [8:0] src_q [NR][$];
  logic [8:0] mq    [NR][$];
  logic [1:0] cap_g [$];
  logic [7:0] cap_d [$];
  logic [1:0] exp_g [$];
  logic [7:0] exp_d [$];
  int         ready_mode = 0;

  logic [NR-1:0] hs;
  logic          prev_tv  = 1'b0;
  logic          prev_rdy = 1'b0;
  logic [7:0]    prev_td  = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sources: present queue heads, pop on handshake, hold until accepted.
  // Also records every UART handshake and checks tx stability / fall.
  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_ready  = 1'b0;
    forever begin
      @(negedge clk);
      hs = rst ? '0 : (req_valid & req_ready);
      if (!rst) begin
        if (prev_tv && !prev_rdy) begin
          chk("tx_hold_valid", tx_valid, 1);
          chk("tx_hold_data", tx_data, prev_td);
        end else if (prev_tv && prev_rdy) begin
          chk("tx_fall_after_accept", tx_valid, 0);
        end
      end
      if (!rst && tx_valid && tx_ready) begin
        cap_g.push_back(grant_id);
        cap_d.push_back(tx_data);
      end
      prev_tv  = tx_valid && !rst;
      prev_rdy = tx_ready;
      prev_td  = tx_data;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++)
        if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      for (int i = 0; i < NR; i++) begin
        if (src_q[i].size() > 0) begin
          req_valid[i]         = 1'b1;
          req_data[i*DW +: DW] = src_q[i][0][7:0];
          req_last[i]          = src_q[i][0][8];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
      case (ready_mode)
        0:       tx_ready = 1'b0;
        1:       tx_ready = 1'b1;
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic push_msg(input int r, input logic [7:0] d, input logic last);
    src_q[r].push_back({last, d});
  endtask

  task automatic expb(input int g, input logic [7:0] d);
    exp_g.push_back(2'(g));
    exp_d.push_back(d);
  endtask

  task automatic wait_caps(input string name, input int n, input int budget);
    int t = 0;
    while (cap_g.size() < n && t < budget) begin
      tick();
      t++;
    end
    if (cap_g.size() < n) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got %0d bytes expected %0d", name, cap_g.size(), n);
    end
  endtask

  task automatic wait_tx_valid(input string name, input int budget);
    int t = 0;
    while (!tx_valid && t < budget) begin
      tick();
      t++;
    end
    chk({name, "_tx_valid_seen"}, tx_valid, 1);
  endtask

  task automatic cmp_stream(input string name);
    chk({name, "_count"}, cap_g.size(), exp_g.size());
    for (int k = 0; k < exp_g.size() && k < cap_g.size(); k++) begin
      chk($sformatf("%s[%0d]_grant", name, k), cap_g[k], exp_g[k]);
      chk($sformatf("%s[%0d]_data", name, k), cap_d[k], exp_d[k]);
    end
    cap_g.delete(); cap_d.delete();
    exp_g.delete(); exp_d.delete();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    cap_g.delete(); cap_d.delete();
  endtask

  // Message-level reference: round robin over non-empty queues, each grant
  // forwarding bytes until a last byte or MB bytes.
  task automatic model_run(inout int ptr);
    int  g;
    int  n;
    bit  any;
    bit  done;
    logic [8:0] b;
    forever begin
      any = 0;
      g   = 0;
      for (int k = 0; k < NR; k++) begin
        if (!any && mq[(ptr + k) % NR].size() > 0) begin
          any = 1;
          g   = (ptr + k) % NR;
        end
      end
      if (!any) break;
      n    = 0;
      done = 0;
      while (!done) begin
        b = mq[g].pop_front();
        expb(g, b[7:0]);
        n++;
        done = b[8] || (n == MB) || (mq[g].size() == 0);
      end
      ptr = (g + 1) % NR;
    end
  endtask

  typedef struct {
    int         ra;
    int         rb;
    logic [7:0] da;
    logic [7:0] db;
    int         first;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    int ptr;
    bit stable;
    int nmsg, len;

    tbl[0] = '{ra: 0, rb: 3,  da: 8'h10, db: 8'h13, first: 3};
    tbl[1] = '{ra: 0, rb: 2,  da: 8'h20, db: 8'h22, first: 2};
    tbl[2] = '{ra: 3, rb: 1,  da: 8'h33, db: 8'h31, first: 1};
    tbl[3] = '{ra: 2, rb: 3,  da: 8'h42, db: 8'h43, first: 2};
    tbl[4] = '{ra: 1, rb: -1, da: 8'h51, db: 8'h00, first: 1};
    tbl[5] = '{ra: 1, rb: 0,  da: 8'h61, db: 8'h60, first: 0};

    // Reset state
    repeat (3) tick();
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    // Single byte: cycle-by-cycle view
    ready_mode = 1;
    push_msg(1, 8'h55, 1'b1);
    tick();
    tick();
    chk("single_busy", busy, 1);
    chk("single_grant", grant_id, 1);
    chk("single_req_ready", req_ready, 4'b0010);
    tick();
    chk("single_tx_valid", tx_valid, 1);
    chk("single_tx_data", tx_data, 8'h55);
    chk("single_req_ready_drain", req_ready, 0);
    tick();
    chk("single_idle_busy", busy, 0);
    chk("single_idle_tx_valid", tx_valid, 0);
    chk("single_grant_kept", grant_id, 1);
    expb(1, 8'h55);
    cmp_stream("single");

    // Table: pairs of single-byte messages, order fixed by rr_ptr
    for (int i = 0; i < 6; i++) begin
      push_msg(tbl[i].ra, tbl[i].da, 1'b1);
      if (tbl[i].rb >= 0) push_msg(tbl[i].rb, tbl[i].db, 1'b1);
      if (tbl[i].first == tbl[i].ra) begin
        expb(tbl[i].ra, tbl[i].da);
        if (tbl[i].rb >= 0) expb(tbl[i].rb, tbl[i].db);
      end else begin
        expb(tbl[i].rb, tbl[i].db);
        expb(tbl[i].ra, tbl[i].da);
      end
      wait_caps($sformatf("tbl%0d", i), exp_g.size(), 100);
      repeat (3) tick();
      cmp_stream($sformatf("tbl%0d", i));
    end

    // Contention: multi-byte message is not interleaved
    pulse_reset();
    push_msg(0, 8'hA0, 1'b0);
    push_msg(0, 8'hA1, 1'b0);
    push_msg(0, 8'hA2, 1'b1);
    push_msg(2, 8'hB0, 1'b0);
    push_msg(2, 8'hB1, 1'b1);
    expb(0, 8'hA0); expb(0, 8'hA1); expb(0, 8'hA2);
    expb(2, 8'hB0); expb(2, 8'hB1);
    wait_caps("contention", 5, 200);
    repeat (3) tick();
    cmp_stream("contention");

    // Burst cap: req0 loses the grant after MB bytes
    pulse_reset();
    for (int i = 0; i < 6; i++) push_msg(0, 8'hC0 + 8'(i), 1'b0);
    push_msg(1, 8'hD0, 1'b0);
    push_msg(1, 8'hD1, 1'b1);
    for (int i = 0; i < 4; i++) expb(0, 8'hC0 + 8'(i));
    expb(1, 8'hD0); expb(1, 8'hD1);
    expb(0, 8'hC4); expb(0, 8'hC5);
    wait_caps("burst", 8, 300);
    repeat (12) tick();
    cmp_stream("burst");
    chk("burst_released_busy", busy, 0);

    // Timeout: req3 keeps the grant for IT-1 idle cycles, rr_ptr wraps
    push_msg(3, 8'h33, 1'b0);
    expb(3, 8'h33);
    wait_caps("timeout_byte", 1, 50);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (req_ready[3]) cnt++;
    end
    chk("timeout_grant_cycles", cnt, IT - 1);
    chk("timeout_busy", busy, 0);
    chk("timeout_grant_kept", grant_id, 3);
    cmp_stream("timeout");
    push_msg(0, 8'h40, 1'b1);
    push_msg(3, 8'h43, 1'b1);
    expb(0, 8'h40); expb(3, 8'h43);
    wait_caps("wrap", 2, 100);
    repeat (3) tick();
    cmp_stream("wrap");

    // Backpressure: byte held for 50 cycles, then a single accept
    ready_mode = 0;
    push_msg(2, 8'h3C, 1'b1);
    wait_tx_valid("bp", 20);
    stable = 1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (!(tx_valid && tx_data == 8'h3C && req_ready == '0 && busy)) stable = 0;
    end
    chk("bp_stable", stable, 1);
    chk("bp_no_accept", cap_g.size(), 0);
    ready_mode = 1;
    expb(2, 8'h3C);
    wait_caps("bp_release", 1, 20);
    repeat (3) tick();
    chk("bp_tx_valid_low", tx_valid, 0);
    cmp_stream("bp");

    // Reset while a byte is held in DRAIN
    ready_mode = 0;
    push_msg(2, 8'h6D, 1'b1);
    wait_tx_valid("rst_drain", 20);
    rst = 1'b1;
    tick();
    chk("rst_drain_tx_valid", tx_valid, 0);
    chk("rst_drain_busy", busy, 0);
    chk("rst_drain_req_ready", req_ready, 0);
    chk("rst_drain_grant", grant_id, 0);
    rst = 1'b0;
    ready_mode = 1;
    tick();
    push_msg(1, 8'h11, 1'b1);
    push_msg(3, 8'h13, 1'b1);
    expb(1, 8'h11); expb(3, 8'h13);
    wait_caps("rst_drain_after", 2, 100);
    repeat (3) tick();
    cmp_stream("rst_drain_after");

    // Randomized rounds against the message-level model
    pulse_reset();
    ready_mode = 2;
    ptr = 0;
    for (int r = 0; r < 25; r++) begin
      for (int q = 0; q < NR; q++) begin
        nmsg = int'($urandom_range(0, 2));
        for (int m = 0; m < nmsg; m++) begin
          len = int'($urandom_range(1, 6));
          for (int b = 0; b < len; b++) begin
            logic [8:0] v;
            v = {(b == len - 1), 8'($urandom)};
            src_q[q].push_back(v);
            mq[q].push_back(v);
          end
        end
      end
      model_run(ptr);
      wait_caps($sformatf("rand%0d", r), exp_g.size(), 2000);
      repeat (4) tick();
      cmp_stream($sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
